// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair, with a busy/done handshake.
// Optional accumulate opcodes (MADD/MSUB) are built only when MDU_MADD_EN is defined.
module mdu_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [1:0]       NFlag
);

  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;
  logic [1:0]       nflag_q;
`ifdef MDU_MADD_EN
  logic [W2-1:0]    acc_q;
`endif

  logic [WIDTH-1:0] hi_d, lo_d;
  logic [1:0]       flag_d;
  logic             is_md;
  logic [CW-1:0]    lat;

  // Accepted opcodes that occupy the unit for a latency window.
  always_comb begin
    is_md = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
            (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
`ifdef MDU_MADD_EN
    if ((MDUOp == OP_MADD) || (MDUOp == OP_MSUB)) is_md = 1'b1;
`endif
    lat = ((MDUOp == OP_DIV) || (MDUOp == OP_DIVU)) ? CW'(DIV_CYCLES - 1)
                                                   : CW'(MULT_CYCLES - 1);
  end

  logic [W2-1:0]    prod_s, prod_u;
  logic             a_neg, b_neg, b_zero, s_ovf;
  logic [WIDTH-1:0] abs_a, abs_b, dvs_s, dvs_u, sq, sr, uq, ur;

  // Result datapath, evaluated from the operands latched at the accept edge.
  always_comb begin
    prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    a_neg  = a_q[WIDTH-1];
    b_neg  = b_q[WIDTH-1];
    b_zero = (b_q == '0);
    s_ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    abs_a  = a_neg ? (WIDTH'(0) - a_q) : a_q;
    abs_b  = b_neg ? (WIDTH'(0) - b_q) : b_q;
    // Divisors forced non-zero so the dividers never see zero; that case is overridden below.
    dvs_s  = b_zero ? WIDTH'(1) : abs_b;
    dvs_u  = b_zero ? WIDTH'(1) : b_q;
    sq     = abs_a / dvs_s;
    sr     = abs_a % dvs_s;
    uq     = a_q / dvs_u;
    ur     = a_q % dvs_u;

    hi_d   = hi_q;
    lo_d   = lo_q;
    flag_d = 2'b00;
    case (op_q)
      OP_MULT:  {hi_d, lo_d} = prod_s;
      OP_MULTU: {hi_d, lo_d} = prod_u;
      OP_DIV: begin
        if (b_zero) begin
          lo_d = '1; hi_d = a_q; flag_d[0] = 1'b1;
        end else if (s_ovf) begin
          lo_d = a_q; hi_d = '0; flag_d[1] = 1'b1;
        end else begin
          lo_d = (a_neg ^ b_neg) ? (WIDTH'(0) - sq) : sq;
          hi_d = a_neg ? (WIDTH'(0) - sr) : sr;
        end
      end
      OP_DIVU: begin
        if (b_zero) begin
          lo_d = '1; hi_d = a_q; flag_d[0] = 1'b1;
        end else begin
          lo_d = uq; hi_d = ur;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD: {hi_d, lo_d} = acc_q + prod_s;
      OP_MSUB: {hi_d, lo_d} = acc_q - prod_s;
`endif
      default: ;
    endcase
  end

  // Control FSM and HI/LO/status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nflag_q <= 2'b00;
`ifdef MDU_MADD_EN
      acc_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_md) begin
              op_q    <= MDUOp;
              a_q     <= x;
              b_q     <= y;
              cnt_q   <= lat;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
`ifdef MDU_MADD_EN
              acc_q   <= {hi_q, lo_q};
`endif
            end else if (MDUOp == OP_MTHI) begin
              hi_q <= x;
            end else if (MDUOp == OP_MTLO) begin
              lo_q <= x;
            end
          end
        end
        S_RUN: begin
          if (cnt_q == '0) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            nflag_q <= nflag_q | flag_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign NFlag = nflag_q;

endmodule
